// File: rtl/sc_io_input.sv
// Memory-mapped input responder: synchronises and debounces KEY/SW, latches
// sticky press/change events, serves register reads and raises a level irq.
module sc_io_input #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FF40,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic        irq
);

  localparam int unsigned NK = 4;
  localparam int unsigned NS = 10;
  localparam int unsigned NB = NK + NS;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] OFF_SW_STATE  = 3'd0;
  localparam logic [2:0] OFF_KEY_STATE = 3'd1;
  localparam logic [2:0] OFF_KEY_EDGE  = 3'd2;
  localparam logic [2:0] OFF_SW_CHG    = 3'd3;
  localparam logic [2:0] OFF_IRQ_EN    = 3'd4;
  localparam logic [2:0] OFF_STATUS    = 3'd5;

  logic [NK-1:0] key_s1_q, key_s2_q;
  logic [NS-1:0] sw_s1_q, sw_s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NB-1:0] hist0_q, hist1_q, hist2_q;
  logic [NB-1:0] hist0_d, hist1_d, hist2_d;
  logic [NB-1:0] deb_q, deb_d;
  logic [NK-1:0] key_edge_q, key_edge_d;
  logic [NS-1:0] sw_chg_q, sw_chg_d;
  logic [NB-1:0] irq_en_q, irq_en_d;
  logic [1:0]    tick_cnt_q, tick_cnt_d;
  logic          primed_q, primed_d;
  logic          irq_q, irq_d;

  logic [NB-1:0] in_sync_c;
  logic [NB-1:0] agree_c;
  logic [NK-1:0] key_set_c, key_clr_c;
  logic [NS-1:0] sw_set_c, sw_clr_c;
  logic [2:0]    off_c;
  logic          tick_c;
  logic          wr_en_c;
  logic          unused_c;

  // Decode: window hit, word offset and write strobe; key polarity fixed to pressed=1
  assign hit       = (addr[31:5] == BASE_ADDR[31:5]);
  assign off_c     = addr[4:2];
  assign wr_en_c   = we & hit;
  assign tick_c    = (cnt_q == CNT_MAX);
  assign in_sync_c = {sw_s2_q, ~key_s2_q};
  assign unused_c  = ^{addr[1:0], wdata[31:NB]};
  assign irq       = irq_q;

  // Next-state: prescaler, debounce history, event flags, enables and irq
  always_comb begin
    cnt_d      = tick_c ? '0 : cnt_q + CW'(1);
    hist0_d    = hist0_q;
    hist1_d    = hist1_q;
    hist2_d    = hist2_q;
    deb_d      = deb_q;
    tick_cnt_d = tick_cnt_q;
    primed_d   = primed_q;
    agree_c    = '0;

    if (tick_c) begin
      hist0_d = in_sync_c;
      hist1_d = hist0_q;
      hist2_d = hist1_q;
      // Debounced value moves on the tick that completes three agreeing samples
      agree_c = ~(hist0_d ^ hist1_d) & ~(hist1_d ^ hist2_d);
      deb_d   = (agree_c & hist0_d) | (~agree_c & deb_q);
      if (!primed_q) begin
        tick_cnt_d = tick_cnt_q + 2'd1;
        if (tick_cnt_q == 2'd2) primed_d = 1'b1;
      end
    end

    key_set_c = primed_q ? (deb_d[NK-1:0] & ~deb_q[NK-1:0]) : '0;
    sw_set_c  = primed_q ? (deb_d[NB-1:NK] ^ deb_q[NB-1:NK]) : '0;
    key_clr_c = (wr_en_c && off_c == OFF_KEY_EDGE) ? wdata[NK-1:0] : '0;
    sw_clr_c  = (wr_en_c && off_c == OFF_SW_CHG) ? wdata[NS-1:0] : '0;

    // A set in the same cycle as a clear keeps the flag
    key_edge_d = (key_edge_q & ~key_clr_c) | key_set_c;
    sw_chg_d   = (sw_chg_q & ~sw_clr_c) | sw_set_c;
    irq_en_d   = (wr_en_c && off_c == OFF_IRQ_EN) ? wdata[NB-1:0] : irq_en_q;
    irq_d      = |({sw_chg_q, key_edge_q} & irq_en_q);
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_s1_q   <= '0;
      key_s2_q   <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      cnt_q      <= '0;
      hist0_q    <= '0;
      hist1_q    <= '0;
      hist2_q    <= '0;
      deb_q      <= '0;
      key_edge_q <= '0;
      sw_chg_q   <= '0;
      irq_en_q   <= '0;
      tick_cnt_q <= '0;
      primed_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      key_s1_q   <= KEY;
      key_s2_q   <= key_s1_q;
      sw_s1_q    <= SW;
      sw_s2_q    <= sw_s1_q;
      cnt_q      <= cnt_d;
      hist0_q    <= hist0_d;
      hist1_q    <= hist1_d;
      hist2_q    <= hist2_d;
      deb_q      <= deb_d;
      key_edge_q <= key_edge_d;
      sw_chg_q   <= sw_chg_d;
      irq_en_q   <= irq_en_d;
      tick_cnt_q <= tick_cnt_d;
      primed_q   <= primed_d;
      irq_q      <= irq_d;
    end
  end

  // Side-effect-free read mux; zero outside the window
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off_c)
        OFF_SW_STATE:  rdata = {22'b0, deb_q[NB-1:NK]};
        OFF_KEY_STATE: rdata = {28'b0, deb_q[NK-1:0]};
        OFF_KEY_EDGE:  rdata = {28'b0, key_edge_q};
        OFF_SW_CHG:    rdata = {22'b0, sw_chg_q};
        OFF_IRQ_EN:    rdata = {18'b0, irq_en_q};
        OFF_STATUS:    rdata = {30'b0, primed_q, irq_q};
        default:       rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_io_input.sv
// Directed bench for sc_io_input with a queue-based scoreboard and monitor.
module tb_sc_io_input;

  localparam logic [31:0] BASE = 32'hFFFF_FF40;

  logic        clock;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        hit;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic        irq;
  logic        chk_req;
  int          edges;
  int          n_vec;
  int          n_miss;

  typedef struct {
    int          kind;   // 0 rdata, 1 irq, 2 hit
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  sc_io_input #(
    .BASE_ADDR      (BASE),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .hit   (hit),
    .KEY   (KEY),
    .SW    (SW),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  // Cycles since reset release; used to predict tick-aligned events
  always @(posedge clock or negedge resetn) begin
    if (!resetn) edges <= 0;
    else         edges <= edges + 1;
  end

  // Monitor: on each check request pop the expected value and compare
  always @(negedge clock) begin
    if (chk_req) begin
      exp_t        e;
      logic [31:0] act;
      n_vec = n_vec + 1;
      if (exp_q.size() == 0) begin
        n_miss = n_miss + 1;
        $display("FAIL scoreboard_underflow: check requested with no expected value");
      end else begin
        e = exp_q.pop_front();
        case (e.kind)
          1:       act = {31'b0, irq};
          2:       act = {31'b0, hit};
          default: act = rdata;
        endcase
        if (act !== e.exp) begin
          n_miss = n_miss + 1;
          $display("FAIL %s: got 32'h%08h expected 32'h%08h", e.name, act, e.exp);
        end
      end
    end
  end

  // One bus cycle, entered and left at posedge+1; optionally queues a check
  task automatic step(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic chk, input int kind, input logic [31:0] ev,
                      input string nm);
    exp_t e;
    addr  = a;
    we    = w;
    wdata = wd;
    if (chk) begin
      e.kind = kind;
      e.exp  = ev;
      e.name = nm;
      exp_q.push_back(e);
    end
    chk_req = chk;
    @(posedge clock);
    #1;
    we      = 1'b0;
    chk_req = 1'b0;
  endtask

  task automatic rd(input logic [4:0] off, input logic [31:0] ev, input string nm);
    step(BASE + 32'(off), 1'b0, 32'h0, 1'b1, 0, ev, nm);
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    step(BASE + 32'(off), 1'b1, d, 1'b0, 0, 32'h0, "");
  endtask

  task automatic chk_irq(input logic ev, input string nm);
    step(32'h0, 1'b0, 32'h0, 1'b1, 1, {31'b0, ev}, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) step(32'h0, 1'b0, 32'h0, 1'b0, 0, 32'h0, "");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          t1;
    int          tgt;
    int          n;
    exp_t        e;
    clock   = 1'b0;
    resetn  = 1'b0;
    addr    = '0;
    wdata   = '0;
    we      = 1'b0;
    chk_req = 1'b0;
    KEY     = 4'hF;
    SW      = 10'h2A5;
    n_vec   = 0;
    n_miss  = 0;
    repeat (3) @(posedge clock);
    #1;

    // Reset values, then priming with switches held at reset
    rd(5'h00, 32'h0, "rst_sw_state");
    chk_irq(1'b0, "rst_irq");
    rd(5'h14, 32'h0, "rst_status");
    resetn = 1'b1;
    idle(14);
    rd(5'h00, 32'h2A5, "prime_sw_state");
    rd(5'h0C, 32'h0,   "prime_sw_chg");
    rd(5'h14, 32'h2,   "prime_status");
    rd(5'h04, 32'h0,   "prime_key_state");
    rd(5'h08, 32'h0,   "prime_key_edge");
    rd(5'h18, 32'h0,   "reserved_18");
    step(BASE,          1'b0, 32'h0, 1'b1, 2, 32'h1, "hit_in");
    step(BASE + 32'h20, 1'b0, 32'h0, 1'b1, 2, 32'h0, "hit_out");
    step(BASE - 32'h20, 1'b0, 32'h0, 1'b1, 0, 32'h0, "rdata_out");

    // Press KEY[1], clear its edge, then release
    KEY[1] = 1'b0;
    idle(20);
    rd(5'h04, 32'h2, "k1_state");
    rd(5'h08, 32'h2, "k1_edge");
    wr(5'h08, 32'h2);
    rd(5'h08, 32'h0, "k1_edge_clr");
    rd(5'h04, 32'h2, "k1_state_held");
    KEY[1] = 1'b1;
    idle(20);
    rd(5'h04, 32'h0, "k1_released");
    rd(5'h08, 32'h0, "k1_release_no_edge");

    // Bouncing KEY[0] never settles pressed
    KEY[0] = 1'b0; idle(4);
    KEY[0] = 1'b1; idle(4);
    KEY[0] = 1'b0; idle(4);
    KEY[0] = 1'b1; idle(20);
    rd(5'h04, 32'h0, "bounce_state");
    rd(5'h08, 32'h0, "bounce_edge");

    // Switch-change interrupt and its W1C release
    wr(5'h10, 32'h10);
    rd(5'h10, 32'h10, "irq_en_rw");
    SW = 10'h2A4;
    n = 0;
    while (irq !== 1'b1 && n < 16) begin
      idle(1);
      n = n + 1;
    end
    chk_irq(1'b1, "sw_irq_set");
    rd(5'h0C, 32'h1,   "sw_chg_set");
    rd(5'h00, 32'h2A4, "sw_state_new");
    wr(5'h0C, 32'h1);
    chk_irq(1'b1, "irq_hold_one_cycle");
    chk_irq(1'b0, "irq_cleared");
    rd(5'h0C, 32'h0, "sw_chg_clr");

    // Press debounced on the same edge as a W1C of that bit
    KEY[0] = 1'b0;
    t1  = ((edges + 6) / 4) * 4;
    tgt = t1 + 8;
    while (edges < tgt - 1) idle(1);
    step(BASE + 32'h08, 1'b1, 32'h1, 1'b1, 0, 32'h0, "k0_edge_before");
    rd(5'h08, 32'h1, "set_wins_over_clr");
    rd(5'h04, 32'h1, "k0_state");

    // All keys pressed, key interrupts enabled, then asynchronous reset
    KEY = 4'h0;
    idle(20);
    rd(5'h08, 32'hF, "all_edges");
    wr(5'h10, 32'hF);
    rd(5'h10, 32'hF, "irq_en_keys");
    chk_irq(1'b1, "key_irq");
    SW = 10'h155;
    idle(5);
    addr   = BASE + 32'h08;
    e.kind = 0;
    e.exp  = 32'h0;
    e.name = "async_key_edge";
    exp_q.push_back(e);
    #2;
    resetn  = 1'b0;
    chk_req = 1'b1;
    @(posedge clock);
    #1;
    chk_req = 1'b0;
    chk_irq(1'b0, "async_irq");
    rd(5'h04, 32'h0, "async_key_state");
    rd(5'h00, 32'h0, "async_sw_state");
    rd(5'h10, 32'h0, "async_irq_en");
    rd(5'h14, 32'h0, "async_status");
    resetn = 1'b1;
    idle(14);
    rd(5'h00, 32'h155, "reprime_sw_state");
    rd(5'h04, 32'hF,   "reprime_key_state");
    rd(5'h08, 32'h0,   "reprime_key_edge");
    rd(5'h0C, 32'h0,   "reprime_sw_chg");
    wr(5'h00, 32'h0);
    rd(5'h00, 32'h155, "ro_write_ignored");
    rd(5'h14, 32'h2,   "reprime_status");

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sc_io_input.md
Name: sc_io_input

Overview:
- Memory-mapped input responder on the hub's CPU-side bus. It is the read-direction counterpart of the LED/seven-segment output path.
- Synchronises and debounces KEY[3:0] and SW[9:0], latches sticky press/change events, and returns register contents to the CPU on reads.
- Raises a level interrupt request when an enabled event is pending.
- Instantiated beside the hub; the hub muxes rdata onto cpu_memout when hit=1.

Parameters:
- BASE_ADDR, 32'hFFFF_FF40, word-aligned base of the 32-byte register window (addr[31:5] compared).
- DEBOUNCE_CYCLES, 50000, clock cycles between debounce samples (1 ms at 50 MHz); legal range is 2 or more.

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- resetn  input  1  asynchronous active-low reset
- addr  input  32  CPU byte address (aluout)
- wdata  input  32  CPU store data
- we  input  1  CPU store strobe (cpu_wmem)
- rdata  output  32  read data, combinational from addr
- hit  output  1  1 when addr is inside the window
- KEY  input  4  raw push buttons, active-low (0 = pressed)
- SW  input  10  raw slide switches
- irq  output  1  interrupt request, level

Behaviour:
- Reset (resetn=0, asynchronous): all of the following clear to 0: synchronisers, prescaler, sample history, debounced state, KEY_EDGE, SW_CHG, IRQ_EN, primed flag.
  - Debounced KEY state resets to 0 (not pressed).
  - rdata follows addr combinationally (reads 0 for zeroed registers); irq resets to 0.
- Synchronisers: 2-flop synchroniser per input bit. KEY is inverted after synchronisation, so pressed reads 1.
- Prescaler:
  - Counts 0 to DEBOUNCE_CYCLES-1 and wraps.
  - tick=1 for one cycle when the count equals DEBOUNCE_CYCLES-1.
- Debounce (per bit):
  - On each tick, shift the synchronised value into a 3-deep history.
  - The debounced bit updates only when all 3 history entries agree; otherwise it holds.
  - Worst-case latency from a stable raw change to the debounced change is 2 + 3*DEBOUNCE_CYCLES + 1 cycles.
- Primed flag:
  - Set on the 3rd tick after reset.
  - Before it is set, debounced bits may update but never set event flags. This blocks spurious events from SW positions present at reset.
- Event flags:
  - KEY_EDGE[i] is set when debounced key i goes 0->1 (press). Release does not set it.
  - SW_CHG[j] is set on any debounced toggle of switch j.
  - Flags are sticky until cleared by a write-1.
  - If a set and a W1C clear hit the same bit in the same cycle, set wins (the bit stays 1).
- Registers (offset, access):
  - 0x00 SW_STATE, RO: {22'b0, debounced SW}.
  - 0x04 KEY_STATE, RO: {28'b0, debounced pressed}.
  - 0x08 KEY_EDGE, W1C: {28'b0, flags}.
  - 0x0C SW_CHG, W1C: {22'b0, flags}.
  - 0x10 IRQ_EN, RW: bits [13:0]; [3:0] enable KEY_EDGE, [13:4] enable SW_CHG.
  - 0x14 STATUS, RO: {30'b0, primed, irq}.
  - 0x18 and 0x1C: read 0, writes ignored.
- Bus access:
  - Reads are side-effect free; clear-on-read is not used.
  - Writes take effect on the rising edge when we=1 and hit=1. Writes to RO registers are ignored.
  - addr[1:0] is ignored (word access only).
  - When hit=0, rdata = 0 and writes are ignored.
- irq is registered: irq = |({SW_CHG, KEY_EDGE} & IRQ_EN) as of the previous cycle. It drops one cycle after the last enabled flag clears.
- A mid-operation reset discards pending events and history immediately. After release, the primed sequence restarts.

Test Plan (DEBOUNCE_CYCLES=4, BASE_ADDR default):
- Reset with SW=10'h2A5 held: after 3 ticks SW_STATE=32'h2A5 and SW_CHG=0; STATUS reads 32'h2 (primed=1, irq=0).
- KEY[1] driven 0 for 20 cycles: KEY_STATE=32'h2 and KEY_EDGE=32'h2. Then write 32'h2 to 0x08: KEY_EDGE=0 while KEY_STATE stays 32'h2.
- KEY[0] bounce pattern 0,1,0,1 every 4 cycles, then held 1: KEY_STATE and KEY_EDGE remain 0.
- IRQ_EN=32'h10 and SW[0] toggled: irq=1 within 2+13+1 cycles. W1C of 32'h1 to 0x0C: irq=0 one cycle later.
- New press debounced in the same cycle as a W1C of 32'h1 to 0x08: KEY_EDGE bit0 stays 1.
- resetn pulsed low mid-debounce with KEY_EDGE=32'hF: all registers and irq read 0 immediately (asynchronous). A write to 0x00 with hit=1 leaves SW_STATE unchanged.
